// File: rtl/conv_ctrl.sv
// conv_ctrl: address/handshake sequencer for a square 2-D convolution.
// Optional CONV_CTRL_PERF_EN adds a busy-cycle counter on perf_cycles.
module conv_ctrl #(
  parameter int ADDR_W = 20,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  conv_i,
  input  logic [DIM_W-1:0]  core_i,
  input  logic [DIM_W-1:0]  stride,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] cnt_loc,
  output logic [ADDR_W-1:0] core_loc,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              out_valid,
  output logic [DIM_W-1:0]  out_row,
  output logic [DIM_W-1:0]  out_col,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
`ifdef CONV_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int AW = (ADDR_W > 2*DIM_W+2) ? ADDR_W : 2*DIM_W+2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  logic [2:0]       r_state;
  logic [DIM_W-1:0] r_n;
  logic [DIM_W-1:0] r_k;
  logic [DIM_W-1:0] r_s;
  logic [DIM_W-1:0] r_m;
  logic [DIM_W-1:0] r_row;
  logic [DIM_W-1:0] r_col;
  logic [DIM_W-1:0] r_ky;
  logic [DIM_W-1:0] r_kx;
  logic             r_mac_en;
  logic             r_mac_clr;
  logic             r_cfg_err;

  logic             w_cfg_bad;
  logic [DIM_W-1:0] w_div;
  logic [DIM_W-1:0] w_m;
  logic             w_kx_last;
  logic             w_ky_last;
  logic             w_col_last;
  logic             w_row_last;
  logic [AW-1:0]    w_y;
  logic [AW-1:0]    w_x;
  logic [AW-1:0]    w_cnt;
  logic [AW-1:0]    w_core;
  logic             w_addr_on;
  logic             w_emit;

  assign w_cfg_bad = (r_k == '0) || (r_s == '0) || (r_k > r_n);
  // Division is only consumed when the config is legal; guard S==0 anyway.
  assign w_div = (r_s == '0) ? '0 : (r_n - r_k) / r_s;
  assign w_m   = w_div + ONE;

  assign w_kx_last  = (r_kx == r_k - ONE);
  assign w_ky_last  = (r_ky == r_k - ONE);
  assign w_col_last = (r_col == r_m - ONE);
  assign w_row_last = (r_row == r_m - ONE);

  assign w_y    = AW'(r_row) * AW'(r_s) + AW'(r_ky);
  assign w_x    = AW'(r_col) * AW'(r_s) + AW'(r_kx);
  assign w_cnt  = w_y * AW'(r_n) + w_x + AW'(1);
  assign w_core = AW'(r_ky) * AW'(r_k) + AW'(r_kx) + AW'(1);

  // Tap counters freeze on the last tap, so DRAIN/EMIT hold the last address.
  assign w_addr_on = (r_state == S_MAC) || (r_state == S_DRAIN) ||
                     (r_state == S_EMIT);
  assign w_emit    = (r_state == S_EMIT);

  assign cnt_loc   = w_addr_on ? w_cnt[ADDR_W-1:0]  : '0;
  assign core_loc  = w_addr_on ? w_core[ADDR_W-1:0] : '0;
  assign mac_en    = r_mac_en;
  assign mac_clr   = r_mac_clr;
  assign out_valid = w_emit;
  assign out_row   = w_emit ? r_row : '0;
  assign out_col   = w_emit ? r_col : '0;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);
  assign cfg_err   = r_cfg_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_n       <= '0;
      r_k       <= '0;
      r_s       <= '0;
      r_m       <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_ky      <= '0;
      r_kx      <= '0;
      r_mac_en  <= 1'b0;
      r_mac_clr <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_mac_en  <= (r_state == S_MAC);
      r_mac_clr <= (r_state == S_MAC) && (r_kx == '0) && (r_ky == '0);
      r_cfg_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n     <= conv_i;
            r_k     <= core_i;
            r_s     <= stride;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_cfg_bad) begin
            r_cfg_err <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_m     <= w_m;
            r_row   <= '0;
            r_col   <= '0;
            r_ky    <= '0;
            r_kx    <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          if (!w_kx_last) begin
            r_kx <= r_kx + ONE;
          end else if (!w_ky_last) begin
            r_kx <= '0;
            r_ky <= r_ky + ONE;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_state <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            r_kx <= '0;
            r_ky <= '0;
            if (w_col_last) begin
              r_col <= '0;
              if (w_row_last) begin
                r_state <= S_FIN;
              end else begin
                r_row   <= r_row + ONE;
                r_state <= S_MAC;
              end
            end else begin
              r_col   <= r_col + ONE;
              r_state <= S_MAC;
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CONV_CTRL_PERF_EN
  logic [31:0] r_perf;

  // FIN is excluded so the count freezes at the value shown with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_perf <= '0;
    end else if (busy && (r_state != S_FIN)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_conv_ctrl.sv
// tb_conv_ctrl: directed self-checking bench for conv_ctrl.
// Covers nominal run, stride windows, config rejects, stall, reset, start-while-busy.
module tb_conv_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  conv_i;
  logic [7:0]  core_i;
  logic [7:0]  stride;
  logic        out_ready;
  logic [19:0] cnt_loc;
  logic [19:0] core_loc;
  logic        mac_clr;
  logic        mac_en;
  logic        out_valid;
  logic [7:0]  out_row;
  logic [7:0]  out_col;
  logic        busy;
  logic        done;
  logic        cfg_err;
`ifdef CONV_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  int n_checks;
  int n_errors;

  conv_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .conv_i    (conv_i),
    .core_i    (core_i),
    .stride    (stride),
    .out_ready (out_ready),
    .cnt_loc   (cnt_loc),
    .core_loc  (core_loc),
    .mac_clr   (mac_clr),
    .mac_en    (mac_en),
    .out_valid (out_valid),
    .out_row   (out_row),
    .out_col   (out_col),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err)
`ifdef CONV_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".cnt_loc"}, 32'(cnt_loc), 0);
    check({tag, ".core_loc"}, 32'(core_loc), 0);
    check({tag, ".mac_clr"}, 32'(mac_clr), 0);
    check({tag, ".mac_en"}, 32'(mac_en), 0);
    check({tag, ".out_valid"}, 32'(out_valid), 0);
    check({tag, ".out_row"}, 32'(out_row), 0);
    check({tag, ".out_col"}, 32'(out_col), 0);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".done"}, 32'(done), 0);
    check({tag, ".cfg_err"}, 32'(cfg_err), 0);
`ifdef CONV_CTRL_PERF_EN
    check({tag, ".perf"}, perf_cycles, 0);
`endif
  endtask

  // N=10 K=3 S=4, M=2: window w occupies cycles 2+11w .. 12+11w.
  task automatic run_a(input bit poke, input int stop_at);
    int tbl0 [9] = '{1, 2, 3, 11, 12, 13, 21, 22, 23};
    int tbl1 [9] = '{5, 6, 7, 15, 16, 17, 25, 26, 27};
    conv_i = 8'd10; core_i = 8'd3; stride = 8'd4; out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 50; t++) begin
      int p;
      int w;
      int ky;
      int kx;
      p = -1;
      w = 0;
      if (t >= 2 && t <= 45) begin
        p = (t - 2) % 11;
        w = (t - 2) / 11;
      end
      check($sformatf("A.busy@%0d", t), 32'(busy), 32'(t <= 46));
      check($sformatf("A.done@%0d", t), 32'(done), 32'(t == 46));
      check($sformatf("A.cfg_err@%0d", t), 32'(cfg_err), 0);
      check($sformatf("A.mac_en@%0d", t), 32'(mac_en),
            32'(p >= 1 && p <= 9));
      check($sformatf("A.mac_clr@%0d", t), 32'(mac_clr), 32'(p == 1));
      check($sformatf("A.valid@%0d", t), 32'(out_valid), 32'(p == 10));
      if (p == 10) begin
        check($sformatf("A.row@%0d", t), 32'(out_row), 32'(w / 2));
        check($sformatf("A.col@%0d", t), 32'(out_col), 32'(w % 2));
      end
      if (p >= 0 && p <= 8) begin
        ky = p / 3;
        kx = p % 3;
        check($sformatf("A.core_loc@%0d", t), 32'(core_loc),
              32'(ky * 3 + kx + 1));
        if (w == 0)
          check($sformatf("A.cnt0@%0d", t), 32'(cnt_loc), 32'(tbl0[p]));
        else if (w == 1)
          check($sformatf("A.cnt1@%0d", t), 32'(cnt_loc), 32'(tbl1[p]));
        else
          check($sformatf("A.cnt@%0d", t), 32'(cnt_loc),
                32'(((w / 2) * 4 + ky) * 10 + (w % 2) * 4 + kx + 1));
      end
`ifdef CONV_CTRL_PERF_EN
      if (t >= 46)
        check($sformatf("A.perf@%0d", t), perf_cycles, 45);
`endif
      if (t == stop_at) return;
      if (poke && (t == 5 || t == 20)) begin
        start = 1'b1; conv_i = 8'd3; core_i = 8'd1;
      end else begin
        start = 1'b0; conv_i = 8'd10; core_i = 8'd3;
      end
      tick();
    end
  endtask

  task automatic run_bad(input string tag, input logic [7:0] n,
                         input logic [7:0] k, input logic [7:0] s);
    conv_i = n; core_i = k; stride = s; out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      check($sformatf("%s.busy@%0d", tag, t), 32'(busy), 32'(t == 1));
      check($sformatf("%s.cfg_err@%0d", tag, t), 32'(cfg_err), 32'(t == 2));
      check($sformatf("%s.mac_en@%0d", tag, t), 32'(mac_en), 0);
      check($sformatf("%s.valid@%0d", tag, t), 32'(out_valid), 0);
      check($sformatf("%s.done@%0d", tag, t), 32'(done), 0);
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    conv_i = '0; core_i = '0; stride = '0;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    run_a(1'b0, 0);

    run_a(1'b0, 4);
    rst = 1'b1;
    tick();
    check_zero("midrst");
    rst = 1'b0;
    run_a(1'b0, 0);

    rst = 1'b1; start = 1'b1;
    conv_i = 8'd10; core_i = 8'd3; stride = 8'd4;
    tick();
    rst = 1'b0; start = 1'b0;
    check_zero("rst_start");
    tick();
    check("rst_start.busy2", 32'(busy), 0);

    run_bad("k_gt_n", 8'd10, 8'd11, 8'd1);
    run_bad("s_zero", 8'd10, 8'd3, 8'd0);
    run_bad("k_zero", 8'd10, 8'd0, 8'd1);

    conv_i = 8'd3; core_i = 8'd3; stride = 8'd1; out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 11; t++) begin
      if (t == 10)
        check("stall.last_tap", 32'(cnt_loc), 9);
      tick();
    end
    for (int t = 12; t <= 16; t++) begin
      check($sformatf("stall.valid@%0d", t), 32'(out_valid), 1);
      check($sformatf("stall.row@%0d", t), 32'(out_row), 0);
      check($sformatf("stall.col@%0d", t), 32'(out_col), 0);
      check($sformatf("stall.cnt@%0d", t), 32'(cnt_loc), 9);
      check($sformatf("stall.mac_en@%0d", t), 32'(mac_en), 0);
      check($sformatf("stall.done@%0d", t), 32'(done), 0);
      tick();
    end
    check("stall.valid@17", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    check("stall.done@18", 32'(done), 1);
    check("stall.valid@18", 32'(out_valid), 0);
    tick();
    check("stall.done@19", 32'(done), 0);
    check("stall.busy@19", 32'(busy), 0);

    run_a(1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
